// File: rtl/mac_tile_wbank.sv
// Systolic MAC processing element with a NUM_W-deep weight bank, supporting WS and OS modes.
// Latency: one cycle for every east/south forward. out_s is combinational from registered state in WS mode.
// Backpressure: none. Build option MAC_TILE_SAT_EN saturates the accumulate; without it the accumulate wraps.
module mac_tile_wbank #(
  parameter  int BW      = 4,
  parameter  int PSUM_BW = 16,
  parameter  int NUM_W   = 2,
  localparam int WSW     = $clog2(NUM_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [BW-1:0]      in_w,
  output logic [BW-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [WSW-1:0]     wsel_w,
  output logic [WSW-1:0]     wsel_e,
  input  logic [PSUM_BW-1:0] in_n,
  output logic [PSUM_BW-1:0] out_s,
  output logic               w_full
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [WSW-1:0] WPTR_LAST = WSW'(NUM_W - 1);

`ifdef MAC_TILE_SAT_EN
  // The sum is computed wide enough that it can never overflow before clamping.
  localparam int EW = PSUM_BW + 2 * BW + 2;
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};
`else
  // Wrapping arithmetic only needs the low PSUM_BW bits of the product and the sum.
  localparam int EW = PSUM_BW;
`endif

  logic [BW-1:0]      a_q, a_d;
  logic [PSUM_BW-1:0] c_q, c_d;
  logic [WSW-1:0]     wsel_q, wsel_d;
  logic [WSW-1:0]     wptr_q, wptr_d;
  logic [2:0]         inst_q, inst_d;
  logic [1:0]         state_q, state_d;
  logic [BW-1:0]      bank_q [NUM_W];
  logic [BW-1:0]      bank_d [NUM_W];

  logic               rearm;
  logic               not_full;
  logic               bank_wr;
  logic [BW-1:0]      w_cur;
  logic signed [EW-1:0] a_ext, w_ext, c_ext, prod_ext, sum_ext;
  logic [PSUM_BW-1:0] mac_res;

  // Load FSM: fill the bank one weight per load token; rearm in WS takes priority over a write.
  always_comb begin
    rearm    = ~mode & inst_w[2];
    not_full = (state_q != ST_FULL);
    state_d  = state_q;
    wptr_d   = wptr_q;
    bank_wr  = 1'b0;
    if (rearm) begin
      state_d = ST_EMPTY;
      wptr_d  = '0;
    end else if (not_full && inst_w[0]) begin
      bank_wr = 1'b1;
      if (wptr_q == WPTR_LAST) begin
        state_d = ST_FULL;
        wptr_d  = '0;
      end else begin
        state_d = ST_FILL;
        wptr_d  = wptr_q + WSW'(1);
      end
    end
  end

  // Bank write port; the MAC path reads bank_q, so a same-cycle execute sees the old weight.
  always_comb begin
    bank_d = bank_q;
    if (bank_wr) begin
      bank_d[wptr_q] = in_w;
    end
  end

  // MAC: unsigned activation times signed weight plus signed accumulator.
  always_comb begin
    w_cur = '0;
    if ({{(32-WSW){1'b0}}, wsel_q} < 32'(NUM_W)) begin
      w_cur = bank_q[wsel_q];
    end
    a_ext    = {{(EW-BW){1'b0}}, a_q};
    w_ext    = {{(EW-BW){w_cur[BW-1]}}, w_cur};
    c_ext    = {{(EW-PSUM_BW){c_q[PSUM_BW-1]}}, c_q};
    prod_ext = a_ext * w_ext;
    sum_ext  = prod_ext + c_ext;
`ifdef MAC_TILE_SAT_EN
    if (sum_ext > SAT_MAX) begin
      mac_res = SAT_MAX[PSUM_BW-1:0];
    end else if (sum_ext < SAT_MIN) begin
      mac_res = SAT_MIN[PSUM_BW-1:0];
    end else begin
      mac_res = sum_ext[PSUM_BW-1:0];
    end
`else
    mac_res = sum_ext[PSUM_BW-1:0];
`endif
  end

  // Forwarding registers and accumulator update; in OS a drain overrides an execute.
  always_comb begin
    a_d    = a_q;
    wsel_d = wsel_q;
    c_d    = c_q;
    if (inst_w[0] | inst_w[1]) begin
      a_d = in_w;
    end
    if (inst_w[1]) begin
      wsel_d = wsel_w;
    end
    // Until the bank is full, the load token is absorbed here and never forwarded east.
    inst_d = {inst_w[2:1], (not_full ? 1'b0 : inst_w[0])};
    if (!mode) begin
      c_d = in_n;
    end else if (inst_w[2]) begin
      c_d = in_n;
    end else if (inst_w[1]) begin
      c_d = mac_res;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      c_q     <= '0;
      wsel_q  <= '0;
      wptr_q  <= '0;
      inst_q  <= '0;
      state_q <= ST_EMPTY;
      for (int i = 0; i < NUM_W; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      a_q     <= a_d;
      c_q     <= c_d;
      wsel_q  <= wsel_d;
      wptr_q  <= wptr_d;
      inst_q  <= inst_d;
      state_q <= state_d;
      for (int i = 0; i < NUM_W; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign out_e  = a_q;
  assign inst_e = inst_q;
  assign wsel_e = wsel_q;
  assign out_s  = mode ? c_q : mac_res;
  assign w_full = (state_q == ST_FULL);

endmodule

// File: tb/tb_mac_tile_wbank.sv
// Self-checking bench for mac_tile_wbank: directed steps followed by random traffic against a reference model.
// Latency: every check is taken 1 time unit after the rising edge that updates the state.
// Backpressure: none; inputs are driven every cycle.
module tb_mac_tile_wbank;
  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int NUM_W   = 2;
  localparam int WSW     = $clog2(NUM_W);

  logic               clk;
  logic               reset;
  logic               mode;
  logic [BW-1:0]      in_w;
  logic [BW-1:0]      out_e;
  logic [2:0]         inst_w;
  logic [2:0]         inst_e;
  logic [WSW-1:0]     wsel_w;
  logic [WSW-1:0]     wsel_e;
  logic [PSUM_BW-1:0] in_n;
  logic [PSUM_BW-1:0] out_s;
  logic               w_full;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: plain integers, with a weight count and a full flag.
  int m_a, m_c, m_wsel, m_inst, m_cnt;
  int m_bank [NUM_W];
  bit m_full;

  mac_tile_wbank #(.BW(BW), .PSUM_BW(PSUM_BW), .NUM_W(NUM_W)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e),
    .inst_w(inst_w), .inst_e(inst_e), .wsel_w(wsel_w), .wsel_e(wsel_e),
    .in_n(in_n), .out_s(out_s), .w_full(w_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // a * w + c using the model's current registers, returned as a PSUM_BW-bit pattern.
  function automatic int mac_model();
    int w, s;
    w = (m_wsel < NUM_W) ? sx(m_bank[m_wsel], BW) : 0;
    s = m_a * w + sx(m_c, PSUM_BW);
`ifdef MAC_TILE_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s & 32'hFFFF;
  endfunction

  task automatic model_edge();
    int mac, inst0;
    if (reset) begin
      m_a = 0; m_c = 0; m_wsel = 0; m_inst = 0; m_cnt = 0; m_full = 0;
      for (int i = 0; i < NUM_W; i++) m_bank[i] = 0;
    end else begin
      mac   = mac_model();
      inst0 = m_full ? int'(inst_w[0]) : 0;
      if (!mode && inst_w[2]) begin
        m_cnt = 0; m_full = 0;
      end else if (!m_full && inst_w[0]) begin
        m_bank[m_cnt] = int'(in_w);
        m_cnt++;
        if (m_cnt == NUM_W) begin
          m_full = 1; m_cnt = 0;
        end
      end
      if (inst_w[0] || inst_w[1]) m_a = int'(in_w);
      if (inst_w[1]) m_wsel = int'(wsel_w);
      m_inst = int'(inst_w[2]) * 4 + int'(inst_w[1]) * 2 + inst0;
      if (!mode || inst_w[2]) m_c = int'(in_n);
      else if (inst_w[1])     m_c = mac;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("out_s",  32'(out_s),  32'(mode ? m_c : mac_model()));
    check("out_e",  32'(out_e),  32'(m_a));
    check("inst_e", 32'(inst_e), 32'(m_inst));
    check("wsel_e", 32'(wsel_e), 32'(m_wsel));
    check("w_full", 32'(w_full), 32'(m_full));
  endtask

  task automatic cyc(input bit r, input bit md, input int iw, input int ins, input int ws, input int n);
    reset  = r;
    mode   = md;
    in_w   = iw[BW-1:0];
    inst_w = ins[2:0];
    wsel_w = ws[WSW-1:0];
    in_n   = n[PSUM_BW-1:0];
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    bit md;
    bit r;
    // Reset with arbitrary inputs: all outputs zero.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 7),
          $urandom_range(0, NUM_W - 1), $urandom_range(0, 65535));
      check("rst_out_s", 32'(out_s), 0);
      check("rst_w_full", 32'(w_full), 0);
      check("rst_inst_e", 32'(inst_e), 0);
    end
    // Load three tokens: the first two fill the bank, the third goes east.
    cyc(0, 0, 3, 1, 0, 0);
    check("ld1_inst_e", 32'(inst_e), 0);
    check("ld1_full", 32'(w_full), 0);
    cyc(0, 0, 5, 1, 0, 0);
    check("ld2_full", 32'(w_full), 1);
    check("ld2_out_e", 32'(out_e), 5);
    cyc(0, 0, 7, 1, 0, 0);
    check("ld3_inst_e", 32'(inst_e), 1);
    check("ld3_out_e", 32'(out_e), 7);
    // WS execute with bank[1]=5: 2*5+10.
    cyc(0, 0, 2, 2, 1, 10);
    check("ws_mac", 32'(out_s), 20);
    check("ws_wsel_e", 32'(wsel_e), 1);
    check("ws_inst_e", 32'(inst_e), 2);
    // OS accumulate with bank[0]=3 over activations 1,2,3.
    cyc(0, 0, 0, 2, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 0, 0);
    cyc(0, 1, 2, 2, 0, 0);
    cyc(0, 1, 3, 2, 0, 0);
    cyc(0, 1, 0, 2, 0, 0);
    check("os_acc", 32'(out_s), 18);
    cyc(0, 1, 0, 4, 0, 16'h0042);
    check("os_drain", 32'(out_s), 16'h0042);
    // Drain wins over execute.
    cyc(0, 1, 0, 4, 0, 18);
    cyc(0, 1, 0, 6, 0, 0);
    check("os_drain_wins", 32'(out_s), 0);
    // WS rearm, rearm beating a load, then reload {7,1}.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 4, 0, 0);
    check("rearm_full", 32'(w_full), 0);
    cyc(0, 0, 9, 5, 0, 0);
    check("rearm_vs_load", 32'(w_full), 0);
    cyc(0, 0, 7, 1, 0, 0);
    check("reld1_full", 32'(w_full), 0);
    cyc(0, 0, 1, 1, 0, 0);
    check("reld2_full", 32'(w_full), 1);
    // Overflow boundary: 15*7 + 0x7FF0.
    cyc(0, 0, 15, 2, 0, 16'h7FF0);
`ifdef MAC_TILE_SAT_EN
    check("ws_overflow", 32'(out_s), 16'h7FFF);
`else
    check("ws_overflow", 32'(out_s), 16'h8059);
`endif
    // Reset in the middle of a load aborts it.
    cyc(0, 0, 0, 4, 0, 0);
    cyc(0, 0, 6, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 4, 1, 0, 0);
    check("mid_rst_full", 32'(w_full), 0);
    cyc(0, 0, 8, 1, 0, 0);
    check("mid_rst_refull", 32'(w_full), 1);
    // Random traffic; mode only changes on a cycle with no instruction.
    md = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 25) begin
        md = ~md;
        cyc(0, md, $urandom_range(0, 15), 0, $urandom_range(0, NUM_W - 1), $urandom_range(0, 65535));
      end else begin
        r = ($urandom_range(0, 99) == 0);
        cyc(r, md, $urandom_range(0, 15), $urandom_range(0, 7),
            $urandom_range(0, NUM_W - 1), $urandom_range(0, 65535));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
